bd_funnel_reassembler: RTL and testbench

Reassembles multi-chunk BD funnel output words into full-width decoded words. Sits directly upstream of the BD-to-PC serializer: it consumes raw funnel words (leaf code plus one payload chunk) and produces DecodedBDWordChannel words whose payload is the complete, zero-extended leaf payload. Only DUMP_AM (leaf 0, 38 bits) arrives as two chunks; every other leaf passes through as a single chunk. A one-entry output register decouples the funnel from serializer backpressure.

---
 rtl/bd_funnel_reassembler_pkg.sv | 34 +++
 rtl/bd_funnel_reassembler_if.sv | 28 ++
 rtl/bd_funnel_reassembler_channel_out_reg.sv | 40 ++++
 rtl/bd_funnel_reassembler.sv | 86 ++++++++
 tb/tb_bd_funnel_reassembler.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bd_funnel_reassembler_pkg.sv
// Shared constants for the BD funnel reassembler.
// The leaf chunk table is also the serializer's per-leaf table.
package bd_funnel_reassembler_pkg;

  localparam int NBDin      = 34;
  localparam int NBDpayload = 38;
  localparam int Ncode      = 4;
  localparam int Nchunk     = 19;
  localparam int Nfunnel    = 14;

  localparam logic [Ncode-1:0] LeafAM      = 4'd0;
  localparam logic [Ncode-1:0] LeafInvalid = 4'd13;

  localparam logic [1:0] LeafChunks [Nfunnel] = '{
    2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
    2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1
  };

  typedef enum logic {
    IDLE,
    HALF
  } asm_state_e;

  // Codes outside the funnel table behave as single-chunk words.
  function automatic logic [1:0] leaf_chunks(
    input logic [Ncode-1:0] code
  );
    leaf_chunks = 2'd1;
    for (int i = 0; i < Nfunnel; i++) begin
      if (code == Ncode'(i)) leaf_chunks = LeafChunks[i];
    end
  endfunction

endpackage

// File: rtl/bd_funnel_reassembler_if.sv
// Level valid/ack channel carrying a leaf code and payload.
// W sets the payload width (raw or decoded).
interface bd_funnel_reassembler_if
  import bd_funnel_reassembler_pkg::*;
#(
  parameter int W = NBDin
);

  logic             v;
  logic             a;
  logic [Ncode-1:0] leaf_code;
  logic [W-1:0]     payload;

  modport master (
    output v,
    output leaf_code,
    output payload,
    input  a
  );

  modport slave (
    input  v,
    input  leaf_code,
    input  payload,
    output a
  );

endinterface

// File: rtl/bd_funnel_reassembler_channel_out_reg.sv
// One-entry valid/ack output register for decoded words.
// A load and a drain in the same cycle keep v high with no bubble.
module channel_out_reg
  import bd_funnel_reassembler_pkg::*;
#(
  parameter int W = NBDpayload
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Ncode-1:0] load_leaf,
  input  logic [W-1:0]     load_payload,
  output logic             ready,
  bd_funnel_reassembler_if.master out
);

  logic             full;
  logic [Ncode-1:0] leaf_q;
  logic [W-1:0]     payload_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full      <= 1'b0;
      leaf_q    <= '0;
      payload_q <= '0;
    end else if (load) begin
      full      <= 1'b1;
      leaf_q    <= load_leaf;
      payload_q <= load_payload;
    end else if (full && out.a) begin
      full <= 1'b0;
    end
  end

  assign ready         = !full || out.a;
  assign out.v         = full;
  assign out.leaf_code = leaf_q;
  assign out.payload   = payload_q;

endmodule

// File: rtl/bd_funnel_reassembler.sv
// Rebuilds two-chunk DUMP_AM words; other leaves pass through.
// Orphaned low chunks are dropped and counted in err_count.
module bd_funnel_reassembler
  import bd_funnel_reassembler_pkg::*;
(
  input  logic clk,
  input  logic reset,
  bd_funnel_reassembler_if.slave  bd_in,
  bd_funnel_reassembler_if.master dec_out,
  output logic [7:0] err_count
);

  asm_state_e state, state_n;

  logic [Nchunk-1:0]     lo_reg;
  logic                  out_ready;
  logic                  accept;
  logic                  multi;
  logic                  load;
  logic                  lo_load;
  logic                  err_inc;
  logic [Ncode-1:0]      ld_leaf;
  logic [NBDpayload-1:0] ld_payload;

  assign bd_in.a = out_ready;
  assign accept  = bd_in.v && out_ready;
  assign multi   = leaf_chunks(bd_in.leaf_code) == 2'd2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lo_reg    <= '0;
      err_count <= '0;
    end else begin
      state <= state_n;
      if (lo_load) lo_reg <= bd_in.payload[Nchunk-1:0];
      if (err_inc && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

  always_comb begin
    state_n    = state;
    load       = 1'b0;
    lo_load    = 1'b0;
    err_inc    = 1'b0;
    ld_leaf    = bd_in.leaf_code;
    ld_payload = NBDpayload'(bd_in.payload);
    if (accept) begin
      unique case (state)
        IDLE: begin
          if (multi) begin
            lo_load = 1'b1;
            state_n = HALF;
          end else begin
            load = 1'b1;
          end
        end
        HALF: begin
          state_n = IDLE;
          load    = 1'b1;
          if (multi) begin
            ld_leaf    = LeafAM;
            ld_payload = {bd_in.payload[Nchunk-1:0], lo_reg};
          end else begin
            err_inc = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  channel_out_reg #(
    .W (NBDpayload)
  ) u_out (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .load_leaf    (ld_leaf),
    .load_payload (ld_payload),
    .ready        (out_ready),
    .out          (dec_out)
  );

endmodule

// File: tb/tb_bd_funnel_reassembler.sv
// Bench for bd_funnel_reassembler: vector table, corner
// sequences and random traffic against a queue-based model.
module tb_bd_funnel_reassembler;

  logic       clk;
  logic       reset;
  logic [7:0] err_count;

  bd_funnel_reassembler_if #(.W(34)) bd_in ();
  bd_funnel_reassembler_if #(.W(38)) dec_out ();

  bd_funnel_reassembler dut (
    .clk       (clk),
    .reset     (reset),
    .bd_in     (bd_in),
    .dec_out   (dec_out),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          v;
    logic [3:0]  leaf;
    logic [33:0] pay;
    bit          da;
    bit          ev;
    logic [3:0]  el;
    logic [37:0] ep;
    bit          ea;
    int          ee;
  } vec_t;

  function automatic vec_t mk(bit v, logic [3:0] leaf,
                              logic [33:0] pay, bit da,
                              bit ev, logic [3:0] el,
                              logic [37:0] ep, bit ea,
                              int ee);
    vec_t r;
    r.v = v; r.leaf = leaf; r.pay = pay; r.da = da;
    r.ev = ev; r.el = el; r.ep = ep; r.ea = ea; r.ee = ee;
    return r;
  endfunction

  typedef struct {
    logic [3:0]  leaf;
    logic [37:0] pay;
  } word_t;

  word_t       mq[$];
  bit          m_pend;
  logic [18:0] m_lo;
  int          m_err;

  function automatic void model_reset();
    mq.delete();
    m_pend = 1'b0;
    m_lo   = '0;
    m_err  = 0;
  endfunction

  function automatic void model_word(logic [3:0] leaf,
                                     logic [33:0] pay);
    word_t w;
    if (m_pend) begin
      m_pend = 1'b0;
      if (leaf == 4'd0) begin
        w.leaf = 4'd0;
        w.pay  = {pay[18:0], m_lo};
        mq.push_back(w);
        return;
      end
      if (m_err < 255) m_err++;
    end else if (leaf == 4'd0) begin
      m_pend = 1'b1;
      m_lo   = pay[18:0];
      return;
    end
    w.leaf = leaf;
    w.pay  = {4'd0, pay};
    mq.push_back(w);
  endfunction

  // Entered and left at posedge+1; checks happen at posedge+2.
  task automatic cyc(input bit v, input logic [3:0] leaf,
                     input logic [33:0] pay, input bit da,
                     output bit acc);
    bit rdy;
    bit drain;
    bd_in.v         = v;
    bd_in.leaf_code = leaf;
    bd_in.payload   = pay;
    dec_out.a       = da;
    #1;
    rdy = (mq.size() == 0) || da;
    chk("in_a", 64'(bd_in.a), 64'(rdy));
    chk("out_v", 64'(dec_out.v), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_leaf", 64'(dec_out.leaf_code), 64'(mq[0].leaf));
      chk("out_pay", 64'(dec_out.payload), 64'(mq[0].pay));
    end
    chk("err", 64'(err_count), 64'(m_err));
    acc   = v && rdy;
    drain = (mq.size() != 0) && da;
    @(posedge clk);
    #1;
    if (drain) void'(mq.pop_front());
    if (acc) model_word(leaf, pay);
  endtask

  task automatic send(input logic [3:0] leaf,
                      input logic [33:0] pay, input bit da);
    bit acc;
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      cyc(1'b1, leaf, pay, da, acc);
      n++;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic async_reset_check();
    reset = 1'b1;
    #2;
    chk("rst_v", 64'(dec_out.v), 64'd0);
    chk("rst_leaf", 64'(dec_out.leaf_code), 64'd0);
    chk("rst_pay", 64'(dec_out.payload), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  vec_t tv[15];

  initial begin
    bit acc;
    bit hv;
    bit da;
    logic [3:0]  hl;
    logic [33:0] hp;
    int c;

    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bd_in.v         = 1'b0;
    bd_in.leaf_code = '0;
    bd_in.payload   = '0;
    dec_out.a       = 1'b0;
    model_reset();

    tv[0]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tv[1]  = mk(1, 6, 34'h1_2345_6789, 0, 0, 0, 0, 1, 0);
    tv[2]  = mk(0, 0, 0, 0, 1, 6, 38'h01_2345_6789, 0, 0);
    tv[3]  = mk(0, 0, 0, 1, 1, 6, 38'h01_2345_6789, 1, 0);
    tv[4]  = mk(1, 0, 34'h7FFFF, 1, 0, 0, 0, 1, 0);
    tv[5]  = mk(1, 0, 34'h00001, 1, 0, 0, 0, 1, 0);
    tv[6]  = mk(1, 0, 34'h12345, 1, 1, 0, 38'h0F_FFFF, 1, 0);
    tv[7]  = mk(1, 11, 34'hABC, 1, 0, 0, 0, 1, 0);
    tv[8]  = mk(1, 13, 34'h3_FFFF_FFFF, 1, 1, 11, 38'hABC, 1, 1);
    tv[9]  = mk(0, 0, 0, 0, 1, 13, 38'h03_FFFF_FFFF, 0, 1);
    tv[10] = mk(1, 0, 34'h3_0000_0005, 0,
                1, 13, 38'h03_FFFF_FFFF, 0, 1);
    tv[11] = mk(1, 0, 34'h3_0000_0005, 1,
                1, 13, 38'h03_FFFF_FFFF, 1, 1);
    tv[12] = mk(1, 0, 34'h2AAAA, 1, 0, 0, 0, 1, 1);
    tv[13] = mk(0, 0, 0, 1, 1, 0, {19'h2AAAA, 19'h5}, 1, 1);
    tv[14] = mk(0, 0, 0, 1, 0, 0, 0, 1, 1);

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      bd_in.v         = tv[i].v;
      bd_in.leaf_code = tv[i].leaf;
      bd_in.payload   = tv[i].pay;
      dec_out.a       = tv[i].da;
      #1;
      chk($sformatf("t%0d_v", i), 64'(dec_out.v), 64'(tv[i].ev));
      if (tv[i].ev || i == 0) begin
        chk($sformatf("t%0d_leaf", i),
            64'(dec_out.leaf_code), 64'(tv[i].el));
        chk($sformatf("t%0d_pay", i),
            64'(dec_out.payload), 64'(tv[i].ep));
      end
      chk($sformatf("t%0d_ina", i), 64'(bd_in.a), 64'(tv[i].ea));
      chk($sformatf("t%0d_err", i), 64'(err_count), 64'(tv[i].ee));
      @(posedge clk);
      #1;
    end

    bd_in.v = 1'b0;
    async_reset_check();

    // Stalled output for 5 cycles, then in-order drain.
    c = 0;
    for (int w = 1; w <= 3; w++) begin
      acc = 1'b0;
      while (!acc && c < 40) begin
        cyc(1'b1, 4'(w), 34'(w * 16'h111), c >= 5, acc);
        c++;
      end
      if (!acc) chk("bp_timeout", 64'd0, 64'd1);
    end
    repeat (3) cyc(1'b0, 0, 0, 1'b1, acc);

    // Orphaned low chunks saturate the drop counter.
    for (int i = 0; i < 300; i++) begin
      send(4'd0, 34'($urandom), 1'b1);
      send(4'd5, 34'($urandom), 1'b1);
    end
    cyc(1'b0, 0, 0, 1'b0, acc);
    chk("err_sat", 64'(err_count), 64'd255);

    // Reset with a full output register, then inside HALF.
    async_reset_check();
    send(4'd3, 34'h55, 1'b0);
    cyc(1'b0, 0, 0, 1'b0, acc);
    async_reset_check();
    send(4'd0, 34'h11111, 1'b1);
    async_reset_check();
    send(4'd0, 34'h00022, 1'b1);
    send(4'd0, 34'h00033, 1'b1);
    cyc(1'b0, 0, 0, 1'b0, acc);
    chk("fresh_pay", 64'(dec_out.payload),
        64'({19'h33, 19'h22}));
    cyc(1'b0, 0, 0, 1'b1, acc);

    hv = 1'b0;
    hl = '0;
    hp = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!hv) begin
        hv = $urandom_range(0, 3) != 0;
        hl = ($urandom_range(0, 2) == 0) ? 4'd0
             : 4'($urandom_range(0, 15));
        hp = {2'($urandom), 32'($urandom)};
      end
      da = $urandom_range(0, 3) != 0;
      cyc(hv, hl, hp, da, acc);
      if (acc) hv = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
